// File: rtl/iot_filter_core.sv
// Byte-serial IoT filter: assembles bytes into words, groups GROUP words per round,
// and applies a per-round filter function (max/min/avg/extract/exclude/peak max/peak min).
module iot_filter_core #(
    parameter int unsigned WORD_W = 128,
    parameter int unsigned GROUP  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_en,
    input  logic [7:0]        iot_in,
    input  logic [2:0]        fn_sel,
    input  logic [WORD_W-1:0] lo_bound,
    input  logic [WORD_W-1:0] hi_bound,
    output logic              busy,
    output logic              valid,
    output logic [WORD_W-1:0] iot_out
);

    localparam int unsigned BYTES = WORD_W / 8;
    localparam int unsigned BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned GW    = $clog2(GROUP);
    localparam int unsigned WC_W  = (GW > 0) ? GW : 1;
    localparam int unsigned SUM_W = WORD_W + GW;

    localparam logic [2:0] FN_MAX     = 3'd1;
    localparam logic [2:0] FN_MIN     = 3'd2;
    localparam logic [2:0] FN_AVG     = 3'd3;
    localparam logic [2:0] FN_EXTRACT = 3'd4;
    localparam logic [2:0] FN_EXCLUDE = 3'd5;
    localparam logic [2:0] FN_PK_MAX  = 3'd6;
    localparam logic [2:0] FN_PK_MIN  = 3'd7;

    logic [BC_W-1:0]   r_byte_cnt;
    logic [WC_W-1:0]   r_word_cnt;
    logic [WORD_W-1:0] r_shift;
    logic [2:0]        r_fn;
    logic [WORD_W-1:0] r_max;
    logic [WORD_W-1:0] r_min;
    logic [SUM_W-1:0]  r_sum;
    logic [WORD_W-1:0] r_peak;
    logic              r_peak_valid;

    logic              w_last_byte;
    logic              w_last_word;
    logic              w_first;
    logic              w_round_first;
    logic              w_peak_clr;
    logic              w_pv;
    logic [2:0]        w_fn;
    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_max_n;
    logic [WORD_W-1:0] w_min_n;
    logic [SUM_W-1:0]  w_sum_n;
    logic [WORD_W-1:0] w_avg;

    // Word assembly, round framing and running max/min/sum of the round so far
    always_comb begin
        w_last_byte   = in_en && (r_byte_cnt == BC_W'(BYTES - 1));
        w_round_first = (r_word_cnt == '0);
        w_last_word   = w_last_byte && (r_word_cnt == WC_W'(GROUP - 1));
        w_first       = in_en && (r_byte_cnt == '0) && w_round_first;
        w_word        = WORD_W'({r_shift, iot_in});
        w_fn          = w_first ? fn_sel : r_fn;
        w_peak_clr    = w_first && (fn_sel != r_fn);
        w_pv          = w_peak_clr ? 1'b0 : r_peak_valid;
        w_max_n       = (w_round_first || (w_word > r_max)) ? w_word : r_max;
        w_min_n       = (w_round_first || (w_word < r_min)) ? w_word : r_min;
        w_sum_n       = (w_round_first ? SUM_W'(0) : r_sum) + SUM_W'(w_word);
        w_avg         = WORD_W'(w_sum_n >> GW);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_cnt   <= '0;
            r_word_cnt   <= '0;
            r_shift      <= '0;
            r_fn         <= '0;
            r_max        <= '0;
            r_min        <= '0;
            r_sum        <= '0;
            r_peak       <= '0;
            r_peak_valid <= 1'b0;
            busy         <= 1'b0;
            valid        <= 1'b0;
            iot_out      <= '0;
        end else begin
            valid <= 1'b0;

            if (in_en) begin
                r_shift    <= w_word;
                r_byte_cnt <= w_last_byte ? '0 : r_byte_cnt + BC_W'(1);
            end

            if (w_first) begin
                r_fn <= fn_sel;
                busy <= 1'b1;
                if (w_peak_clr) begin
                    r_peak_valid <= 1'b0;
                end
            end

            if (w_last_byte) begin
                r_word_cnt <= w_last_word ? '0 : r_word_cnt + WC_W'(1);
                r_max      <= w_max_n;
                r_min      <= w_min_n;
                r_sum      <= w_sum_n;

                // Per-word pass-through filters; bounds are sampled on this edge
                case (w_fn)
                    FN_EXTRACT: begin
                        if ((lo_bound < w_word) && (w_word < hi_bound)) begin
                            valid   <= 1'b1;
                            iot_out <= w_word;
                        end
                    end
                    FN_EXCLUDE: begin
                        if ((w_word < lo_bound) || (w_word > hi_bound)) begin
                            valid   <= 1'b1;
                            iot_out <= w_word;
                        end
                    end
                    default: ;
                endcase

                if (w_last_word) begin
                    busy <= 1'b0;
                    case (w_fn)
                        FN_MAX: begin
                            valid   <= 1'b1;
                            iot_out <= w_max_n;
                        end
                        FN_MIN: begin
                            valid   <= 1'b1;
                            iot_out <= w_min_n;
                        end
                        FN_AVG: begin
                            valid   <= 1'b1;
                            iot_out <= w_avg;
                        end
                        FN_PK_MAX: begin
                            if (!w_pv || (w_max_n > r_peak)) begin
                                r_peak       <= w_max_n;
                                r_peak_valid <= 1'b1;
                                valid        <= 1'b1;
                                iot_out      <= w_max_n;
                            end
                        end
                        FN_PK_MIN: begin
                            if (!w_pv || (w_min_n < r_peak)) begin
                                r_peak       <= w_min_n;
                                r_peak_valid <= 1'b1;
                                valid        <= 1'b1;
                                iot_out      <= w_min_n;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
